// File: rtl/pipe_flow_ctrl.sv
// Valid/ready flow control for a fixed-latency, clock-enabled, sync-clearable datapath.
// Define PIPE_FLOW_CTRL_BEAT_CNT_EN to add the per-frame output beat counter.
module pipe_flow_ctrl #(
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic                  pipe_clken,
    output logic                  pipe_sclr,
    input  logic [DATA_WIDTH-1:0] pipe_data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  flush,
    output logic                  busy
`ifdef PIPE_FLOW_CTRL_BEAT_CNT_EN
    ,
    output logic [15:0]           frame_beats,
    output logic                  frame_beats_valid
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  live_q;
    logic                  adv;
    logic                  accept;
    logic                  out_hs;
    logic                  wipe;
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [LATENCY-1:0]    lst_q, lst_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    // live_q keeps every enable low until the first edge after reset release.
    assign adv     = live_q && (!m_valid_q || m_ready);
    assign s_ready = adv && (state_q == ST_RUN);
    assign accept  = s_valid && s_ready;
    assign out_hs  = m_valid_q && m_ready;
    assign wipe    = flush || (state_q == ST_CLEAR);

    always_comb begin
        state_d    = state_q;
        pipe_clken = adv;
        pipe_sclr  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (accept && s_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_hs && m_last_q) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pipe_clken = 1'b1;
                pipe_sclr  = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (flush) begin
            state_d = ST_CLEAR;
        end
    end

    always_comb begin
        vld_d     = vld_q;
        lst_d     = lst_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        if (wipe) begin
            vld_d     = '0;
            lst_d     = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else if (adv) begin
            vld_d[0] = accept;
            lst_d[0] = accept && s_last;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                lst_d[i] = lst_q[i-1];
            end
            m_valid_d = vld_q[LATENCY-1];
            m_last_d  = lst_q[LATENCY-1];
            // bubbles leave the last real result on m_data
            if (vld_q[LATENCY-1]) begin
                m_data_d = pipe_data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            live_q    <= 1'b0;
            state_q   <= ST_RUN;
            vld_q     <= '0;
            lst_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            live_q    <= 1'b1;
            state_q   <= state_d;
            vld_q     <= vld_d;
            lst_q     <= lst_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;
    assign busy    = (|vld_q) || m_valid_q || (state_q != ST_RUN);

`ifdef PIPE_FLOW_CTRL_BEAT_CNT_EN
    logic [15:0] beats_q, beats_d;
    logic        beats_vld_q, beats_vld_d;

    // The count that includes the m_last beat is visible during CLEAR, then zeroed.
    always_comb begin
        beats_d     = beats_q;
        beats_vld_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            beats_d = '0;
        end else if (out_hs) begin
            beats_d     = beats_q + 16'd1;
            beats_vld_d = m_last_q;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            beats_q     <= '0;
            beats_vld_q <= 1'b0;
        end else begin
            beats_q     <= beats_d;
            beats_vld_q <= beats_vld_d;
        end
    end

    assign frame_beats       = beats_q;
    assign frame_beats_valid = beats_vld_q;
`endif

endmodule
